serial_subtractor: RTL



---
 rtl/serial_subtractor_pkg.sv | 23 ++
 rtl/serial_subtractor_if.sv | 27 ++
 rtl/serial_subtractor_full_adder_bit.sv | 15 +
 rtl/serial_subtractor.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the helper that sizes the bit counter.
// No ports; imported by the interface-facing modules.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2 with a floor of 1 so a counter always has at least one bit.
  // The loop stops at 30 so the signed shift never reaches the sign bit.
  function automatic int ceil_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle between a sequential controller and the serial
// subtractor. Controller (master) drives start/a/b; subtractor (slave) returns
// busy/done and the registered diff/borrow/overflow results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, overflow
  );

endinterface

// File: rtl/serial_subtractor_full_adder_bit.sv
// One-bit combinational full adder, the per-bit stage of the serial datapath.
// Ports: a, b, cin in; s (sum), cout (carry-out) out. Zero latency.
// No state, no backpressure.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b computed LSB first as a + ~b + 1.
// Latency: WIDTH+1 edges from accepted start to the one-cycle done pulse.
// Backpressure: start is only honoured in IDLE; starts while busy are dropped.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries
// start/a/b in and busy/done/diff/borrow/overflow out, all outputs registered.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  localparam int CNT_W = ceil_log2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] res_shift;

  // Subtrahend bit is inverted here; the +1 comes from the carry seed of 1.
  full_adder_bit u_fa (
    .a    (opa_q[0]),
    .b    (~opb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign res_shift = {fa_s, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = bus.b;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          res_d   = '0;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        res_d   = res_shift;
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_cout;
        if (cnt_q == LAST_BIT) begin
          // Counter is left at its last value rather than wrapping.
          state_d  = ST_DONE;
          diff_d   = res_shift;
          borrow_d = ~fa_cout;
          // Signed overflow only possible when operand signs differ.
          ovf_d    = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they align with it.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.diff     = diff_q;
  assign bus.borrow   = borrow_q;
  assign bus.overflow = ovf_q;

endmodule
